// File: rtl/fp_mult_pkg.sv
// Shared constants and sideband types for the pipelined FP32 multiplier.
// Used by the front-end decode stage and the normalise/round back end.
package fp_mult_pkg;

    localparam int unsigned FP_MANT_W = 24;           // significand width incl. hidden bit
    localparam int unsigned FP_EXP_W  = 8;            // exponent field width
    localparam int unsigned BIAS      = 127;
    localparam int unsigned EXP_MAX   = 255;
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;

    // Special-case sideband carried alongside the significand product
    typedef struct packed {
        logic sign;
        logic nan;
        logic inf;
        logic zero;
    } fp_side_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised significand.
// Ports:
//   mant    in   MANT_W   normalised significand (hidden bit at MSB)
//   g       in   1        guard bit (first bit below mant LSB)
//   s       in   1        sticky bit (OR of all lower bits)
//   m2      out  MANT_W   rounded significand, renormalised to 1.0 on carry-out
//   carry   out  1        rounding carried out of the significand (exponent must +1)
//   inexact out  1        nonzero bits were discarded
module fp_round_rne #(
    parameter int unsigned MANT_W = 24
) (
    input  logic [MANT_W-1:0] mant,
    input  logic              g,
    input  logic              s,
    output logic [MANT_W-1:0] m2,
    output logic              carry,
    output logic              inexact
);

    logic            up;
    logic [MANT_W:0] sum;

    // Round up above half, or on an exact tie when the LSB is odd
    assign up      = g & (s | mant[0]);
    assign sum     = {1'b0, mant} + (MANT_W+1)'(up);
    assign carry   = sum[MANT_W];
    assign m2      = carry ? {1'b1, {(MANT_W-1){1'b0}}} : sum[MANT_W-1:0];
    assign inexact = g | s;

endmodule

// File: rtl/fp32_mult_norm_round.sv
// Back-end of the pipelined FP32 multiplier: normalises the raw significand
// product (stage 1), rounds to nearest-even and packs binary32 (stage 2).
// The whole pipe advances together whenever the output register is free.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_ready               input handshake
//   in_prod                         unsigned significand product (upper bits zero)
//   in_exp                          signed exponent sum ea+eb-BIAS
//   in_sign/in_nan/in_inf/in_zero   sign and special-case sideband
//   out_valid/out_ready             output handshake
//   out_result                      packed binary32
//   out_ovf/out_unf/out_inexact     overflow, flush-to-zero underflow, inexact flags
module fp32_mult_norm_round
    import fp_mult_pkg::*;
#(
    parameter int unsigned PROD_W = 54,
    parameter int unsigned MANT_W = FP_MANT_W,
    parameter int unsigned EXP_W  = FP_EXP_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PROD_W-1:0]   in_prod,
    input  logic [EXP_W+1:0]    in_exp,
    input  logic                in_sign,
    input  logic                in_nan,
    input  logic                in_inf,
    input  logic                in_zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_result,
    output logic                out_ovf,
    output logic                out_unf,
    output logic                out_inexact
);

    localparam int unsigned PW  = 2 * MANT_W;   // live product bits
    localparam int unsigned E_W = EXP_W + 4;    // headroom for two +1 increments

    logic en;

    // Stage-1 combinational normalise
    logic [PW-1:0]     p;
    logic              p_hi;
    logic [MANT_W-1:0] n_mant;
    logic              n_g;
    logic              n_s;
    logic [E_W-1:0]    exp_sx;
    logic [E_W-1:0]    n_e;
    fp_side_t          n_side;

    // Stage-1 registers
    logic              s1_valid;
    logic [MANT_W-1:0] s1_mant;
    logic              s1_g;
    logic              s1_s;
    logic [E_W-1:0]    s1_e;
    fp_side_t          s1_side;

    // Stage-2 combinational round/pack
    logic [MANT_W-1:0] rnd_m2;
    logic              rnd_carry;
    logic              rnd_inexact;
    logic [E_W-1:0]    e_fin;
    logic              e_ovf;
    logic              e_unf;
    logic [31:0]       nxt_result;
    logic              nxt_ovf;
    logic              nxt_unf;
    logic              nxt_inexact;

    // Pipe advances only when the output register is empty or being drained
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Upper product bits are out of contract and dropped by the truncating cast
    assign p      = PW'(in_prod);
    assign p_hi   = p[PW-1];
    assign n_mant = p_hi ? p[PW-1 -: MANT_W] : p[PW-2 -: MANT_W];
    assign n_g    = p_hi ? p[PW-1-MANT_W] : p[PW-2-MANT_W];
    assign n_s    = p_hi ? |p[PW-2-MANT_W:0] : |p[PW-3-MANT_W:0];
    assign exp_sx = {{(E_W-EXP_W-2){in_exp[EXP_W+1]}}, in_exp};
    assign n_e    = exp_sx + {{(E_W-1){1'b0}}, p_hi};
    assign n_side = '{sign: in_sign, nan: in_nan, inf: in_inf, zero: in_zero};

    // Stage 1 register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_g     <= 1'b0;
            s1_s     <= 1'b0;
            s1_e     <= '0;
            s1_side  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_mant  <= n_mant;
            s1_g     <= n_g;
            s1_s     <= n_s;
            s1_e     <= n_e;
            s1_side  <= n_side;
        end
    end

    fp_round_rne #(.MANT_W(MANT_W)) u_round (
        .mant    (s1_mant),
        .g       (s1_g),
        .s       (s1_s),
        .m2      (rnd_m2),
        .carry   (rnd_carry),
        .inexact (rnd_inexact)
    );

    // Exponent after the rounding carry; the MSB is the two's-complement sign
    assign e_fin = s1_e + {{(E_W-1){1'b0}}, rnd_carry};
    assign e_ovf = ~e_fin[E_W-1] & (e_fin >= E_W'(EXP_MAX));
    assign e_unf = e_fin[E_W-1] | (e_fin == '0);

    // Stage-2 pack; specials take priority over arithmetic results
    always_comb begin
        nxt_result  = {s1_side.sign, EXP_W'(e_fin), (MANT_W-1)'(rnd_m2)};
        nxt_ovf     = 1'b0;
        nxt_unf     = 1'b0;
        nxt_inexact = rnd_inexact;
        if (s1_side.nan) begin
            nxt_result  = QNAN;
            nxt_inexact = 1'b0;
        end else if (s1_side.inf) begin
            nxt_result  = {s1_side.sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
            nxt_inexact = 1'b0;
        end else if (s1_side.zero) begin
            nxt_result  = {s1_side.sign, 31'b0};
            nxt_inexact = 1'b0;
        end else if (e_ovf) begin
            nxt_result  = {s1_side.sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
            nxt_ovf     = 1'b1;
            nxt_inexact = 1'b1;
        end else if (e_unf) begin
            nxt_result  = {s1_side.sign, 31'b0};
            nxt_unf     = 1'b1;
            nxt_inexact = 1'b1;
        end
    end

    // Stage 2 / output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (en) begin
            out_valid   <= s1_valid;
            out_result  <= nxt_result;
            out_ovf     <= nxt_ovf;
            out_unf     <= nxt_unf;
            out_inexact <= nxt_inexact;
        end
    end

endmodule

// File: tb/tb_fp32_mult_norm_round.sv
// Directed, table-driven bench for fp32_mult_norm_round plus hand-written
// backpressure and mid-flight reset sequences.
module tb_fp32_mult_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [53:0] in_prod;
    logic [9:0]  in_exp;
    logic        in_sign, in_nan, in_inf, in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf, out_unf, out_inexact;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp32_mult_norm_round dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_prod     (in_prod),
        .in_exp      (in_exp),
        .in_sign     (in_sign),
        .in_nan      (in_nan),
        .in_inf      (in_inf),
        .in_zero     (in_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_ovf     (out_ovf),
        .out_unf     (out_unf),
        .out_inexact (out_inexact)
    );

    typedef struct {
        logic [47:0] prod;
        logic [9:0]  exp;
        logic        sign, nan, inf, zero;
        logic [31:0] res;
        logic        ovf, unf, inex;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_prod  = {6'b0, v.prod};
        in_exp   = v.exp;
        in_sign  = v.sign;
        in_nan   = v.nan;
        in_inf   = v.inf;
        in_zero  = v.zero;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_prod  = '0;
        in_exp   = '0;
        in_sign  = 1'b0;
        in_nan   = 1'b0;
        in_inf   = 1'b0;
        in_zero  = 1'b0;
    endtask

    // Single beat, unstalled: result must appear exactly two cycles after acceptance
    task automatic run_vec(input string name, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        idle();
        chk({name, "_early_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_result"}, out_result, v.res);
        chk({name, "_ovf"}, 32'(out_ovf), 32'(v.ovf));
        chk({name, "_unf"}, 32'(out_unf), 32'(v.unf));
        chk({name, "_inexact"}, 32'(out_inexact), 32'(v.inex));
    endtask

    // Upper product bits must never be driven
    always @(posedge clk) begin
        if (!rst && in_valid) begin
            assert (in_prod[53:48] == 6'b0) else $error("in_prod upper bits nonzero");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        bv;
        int          acc;
        int          rcv;
        logic [31:0] exp_q[5];
        logic        hold_pend;
        logic [31:0] hold_val;

        //            prod                 exp     sg    nan   inf   zero  result         ovf   unf   inex
        vecs[0]  = '{48'h9000_0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{48'h4000_00C0_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{48'h4000_0040_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{48'h7FFF_FFC0_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{48'h8000_0000_0000, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{48'h4000_0000_0000, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{48'h4000_0000_0000, 10'd127, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{48'h4000_0000_0000, 10'd127, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFF80_0000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{48'h4000_0000_0000, 10'd127, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{48'h8000_0000_0000, 10'h3FB, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{48'h4000_0000_0000, 10'd1,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0080_0000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{48'h4000_0000_0000, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F00_0000, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{48'h7FFF_FFC0_0000, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{48'h4000_0000_0001, 10'd127, 1'b1, 1'b0, 1'b0, 1'b0, 32'hBF80_0000, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{48'h4000_0060_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F80_0001, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{48'hC000_0080_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 1'b1};

        // Reset state
        rst       = 1'b1;
        out_ready = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_flags", {29'b0, out_ovf, out_unf, out_inexact}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst       = 1'b0;
        out_ready = 1'b1;

        // Directed vectors
        for (int i = 0; i < NV; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: five beats, downstream stalls on cycles 3..6
        for (int k = 0; k < 5; k++) begin
            exp_q[k] = (32'(127 + k) << 23) | 32'(k);
        end
        acc       = 0;
        rcv       = 0;
        hold_pend = 1'b0;
        hold_val  = '0;
        for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
            @(negedge clk);
            if (hold_pend) begin
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_result", out_result, hold_val);
            end
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (acc < 5) begin
                bv = '{48'h4000_0000_0000 | (48'(acc) << 23), 10'(127 + acc),
                       1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
                drive(bv);
            end else begin
                idle();
            end
            #1;
            if (cyc <= 6) begin
                chk($sformatf("bp_in_ready_c%0d", cyc), 32'(in_ready),
                    (cyc >= 3) ? 32'd0 : 32'd1);
            end
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_result%0d", rcv), out_result, exp_q[rcv]);
                rcv++;
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = out_result;
        end
        chk("bp_count", 32'(rcv), 32'd5);
        idle();
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_no_dup", 32'(out_valid), 32'd0);
        end

        // Reset with two beats in flight
        @(negedge clk);
        drive(vecs[0]);
        @(negedge clk);
        drive(vecs[1]);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_result", out_result, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("mrst_no_stale", 32'(out_valid), 32'd0);
        end
        run_vec("post_rst", vecs[2]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
